ccip_tx_tid_scheduler: RTL and testbench

- Shares one CCI-P TX request channel among NUM_REQ requesters using round-robin arbitration.
- Assigns a transaction ID (tid) to every tracked request and keeps a per-tid scoreboard of owner and remaining response lines.
- Routes each RX response back to the requester that owns it, then frees the tid once the last line returns.
- Sits between the AFU-side request sources and the ASE CCI-P TX/RX interface. It supplies the tid stream that the ASE stream checker consumes.

---
 rtl/ccip_tx_tid_scheduler_pkg.sv | 51 +++++
 rtl/ccip_tx_tid_scheduler_rr_arbiter.sv | 55 +++++
 rtl/ccip_tx_tid_scheduler.sv | 179 +++++++++++++++++
 tb/tb_ccip_tx_tid_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_tx_tid_scheduler_pkg.sv
// CCI-P header types, request/response codes and the per-tid scoreboard entry
// shared by the TX tid scheduler and its users.
package ccip_tx_tid_scheduler_pkg;

    localparam int unsigned OWNER_W = 3;
    localparam int unsigned REM_W   = 3;
    localparam int unsigned TYPE_W  = 4;

    localparam logic [TYPE_W-1:0] CCIP_WRLINE_I = 4'h0;
    localparam logic [TYPE_W-1:0] CCIP_WRLINE_M = 4'h1;
    localparam logic [TYPE_W-1:0] CCIP_WRFENCE  = 4'h4;
    localparam logic [TYPE_W-1:0] CCIP_RDLINE_I = 4'h5;
    localparam logic [TYPE_W-1:0] CCIP_RDLINE_S = 4'h6;

    localparam logic [TYPE_W-1:0] CCIP_RSP_RDLINE  = 4'h0;
    localparam logic [TYPE_W-1:0] CCIP_RSP_WRLINE  = 4'h1;
    localparam logic [TYPE_W-1:0] CCIP_RSP_WRFENCE = 4'h4;

    typedef struct packed {
        logic [15:0]       mdata;
        logic [TYPE_W-1:0] req_type;
        logic [1:0]        len;
        logic [41:0]       addr;
    } TxHdr_t;

    typedef struct packed {
        logic [15:0]       mdata;
        logic [TYPE_W-1:0] resp_type;
        logic [1:0]        clnum;
        logic              hit_miss;
    } RxHdr_t;

    typedef struct packed {
        logic [OWNER_W-1:0] owner;
        logic [REM_W-1:0]   remaining;
        logic               valid;
    } tid_entry_t;

    function automatic logic is_fence(input logic [TYPE_W-1:0] t);
        return t == CCIP_WRFENCE;
    endfunction

    // Reads return len+1 lines; every write returns a single ack.
    function automatic logic [REM_W-1:0] lines_expected(input TxHdr_t h);
        if ((h.req_type == CCIP_RDLINE_I) || (h.req_type == CCIP_RDLINE_S)) begin
            return REM_W'(h.len) + REM_W'(1);
        end
        return REM_W'(1);
    endfunction

endpackage

// File: rtl/ccip_tx_tid_scheduler_rr_arbiter.sv
// N-way round-robin arbiter; priority starts after the last granted requester
// and the pointer only moves when the grant is actually taken.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         gnt_c_o,
    output logic [$clog2(N)-1:0] gnt_idx_c_o
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found_c;

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        gnt_c_o     = '0;
        gnt_idx_c_o = '0;
        found_c     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_c && req_i[i] && (IDX_W'(i) >= ptr_q)) begin
                found_c     = 1'b1;
                gnt_c_o[i]  = 1'b1;
                gnt_idx_c_o = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found_c && req_i[i]) begin
                found_c     = 1'b1;
                gnt_c_o[i]  = 1'b1;
                gnt_idx_c_o = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (gnt_idx_c_o == IDX_W'(N - 1)) ? '0 : gnt_idx_c_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ccip_tx_tid_scheduler.sv
// Shares the CCI-P TX channel among requesters, tags each request with a tid,
// and routes RX responses back to the owner until the tid is released.
module ccip_tx_tid_scheduler
    import ccip_tx_tid_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned TID_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  TxHdr_t [NUM_REQ-1:0] req_hdr,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_almfull,
    output logic                 tx_valid,
    output TxHdr_t               tx_hdr,
    output logic [TID_WIDTH-1:0] tx_tid,
    input  logic                 rx_valid,
    input  RxHdr_t               rx_hdr,
    input  logic [TID_WIDTH-1:0] rx_tid,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output RxHdr_t               rsp_hdr,
    output logic [TID_WIDTH:0]   outstanding,
    output logic                 idle,
    output logic                 err_unknown_tid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = TID_WIDTH + 1;

    tid_entry_t           sb_q [MAX_OUTSTANDING];
    tid_entry_t           sb_d [MAX_OUTSTANDING];
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic                 fence_pend_q, fence_pend_d;
    logic [IDX_W-1:0]     fence_owner_q, fence_owner_d;
    logic                 tx_valid_q, tx_valid_d;
    TxHdr_t               tx_hdr_q, tx_hdr_d;
    logic [TID_WIDTH-1:0] tx_tid_q, tx_tid_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    RxHdr_t               rsp_hdr_q, rsp_hdr_d;
    logic                 err_q, err_d;
    logic                 idle_q, idle_d;

    logic [NUM_REQ-1:0]   eligible_c, gnt_c;
    logic [IDX_W-1:0]     gnt_idx_c;
    logic                 pool_avail_c, hs_c, gnt_fence_c, alloc_c;
    TxHdr_t               gnt_hdr_c;
    logic [TID_WIDTH-1:0] free_tid_c;
    tid_entry_t           rx_entry_c;
    logic                 rx_fence_c, fence_hit_c, rx_hit_c, rx_last_c;

    assign pool_avail_c = outstanding_q != CNT_W'(MAX_OUTSTANDING);

    // Fences only need the single fence slot; everything else needs a free tid.
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !tx_almfull) begin
                eligible_c[i] = is_fence(req_hdr[i].req_type) ? !fence_pend_q : pool_avail_c;
            end
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (eligible_c),
        .advance_i   (hs_c),
        .gnt_c_o     (gnt_c),
        .gnt_idx_c_o (gnt_idx_c)
    );

    assign req_ready   = gnt_c;
    assign hs_c        = |gnt_c;
    assign gnt_hdr_c   = req_hdr[gnt_idx_c];
    assign gnt_fence_c = is_fence(gnt_hdr_c.req_type);
    assign alloc_c     = hs_c && !gnt_fence_c;

    // Lowest free tid as seen at the start of the cycle.
    always_comb begin
        free_tid_c = '0;
        for (int unsigned i = MAX_OUTSTANDING; i > 0; i--) begin
            if (!sb_q[i-1].valid) begin
                free_tid_c = TID_WIDTH'(i - 1);
            end
        end
    end

    assign rx_entry_c  = sb_q[rx_tid];
    assign rx_fence_c  = rx_valid && (rx_hdr.resp_type == CCIP_RSP_WRFENCE);
    assign fence_hit_c = rx_fence_c && fence_pend_q;
    assign rx_hit_c    = rx_valid && !rx_fence_c && rx_entry_c.valid;
    assign rx_last_c   = rx_hit_c && (rx_entry_c.remaining == REM_W'(1));

    always_comb begin
        sb_d          = sb_q;
        fence_pend_d  = fence_pend_q;
        fence_owner_d = fence_owner_q;
        tx_valid_d    = hs_c;
        tx_hdr_d      = tx_hdr_q;
        tx_tid_d      = tx_tid_q;
        rsp_hdr_d     = rx_valid ? rx_hdr : rsp_hdr_q;
        err_d         = rx_valid && !rx_hit_c && !fence_hit_c;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = (rx_hit_c && (rx_entry_c.owner == OWNER_W'(i)))
                          || (fence_hit_c && (fence_owner_q == IDX_W'(i)));
        end

        if (rx_hit_c) begin
            sb_d[rx_tid].remaining = rx_entry_c.remaining - REM_W'(1);
            sb_d[rx_tid].valid     = !rx_last_c;
        end
        if (fence_hit_c) begin
            fence_pend_d = 1'b0;
        end

        if (hs_c) begin
            tx_hdr_d = gnt_hdr_c;
            tx_tid_d = gnt_fence_c ? '0 : free_tid_c;
        end
        if (hs_c && gnt_fence_c) begin
            fence_pend_d  = 1'b1;
            fence_owner_d = gnt_idx_c;
        end
        // The allocated tid was free at cycle start, so it never collides with the response update.
        if (alloc_c) begin
            sb_d[free_tid_c] = '{owner: OWNER_W'(gnt_idx_c),
                                 remaining: lines_expected(gnt_hdr_c),
                                 valid: 1'b1};
        end

        outstanding_d = outstanding_q + CNT_W'(alloc_c) - CNT_W'(rx_last_c);
        idle_d        = (outstanding_d == '0) && !tx_valid_d && !fence_pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < MAX_OUTSTANDING; t++) begin
                sb_q[t] <= '0;
            end
            outstanding_q <= '0;
            fence_pend_q  <= 1'b0;
            fence_owner_q <= '0;
            tx_valid_q    <= 1'b0;
            tx_hdr_q      <= '0;
            tx_tid_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_hdr_q     <= '0;
            err_q         <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            sb_q          <= sb_d;
            outstanding_q <= outstanding_d;
            fence_pend_q  <= fence_pend_d;
            fence_owner_q <= fence_owner_d;
            tx_valid_q    <= tx_valid_d;
            tx_hdr_q      <= tx_hdr_d;
            tx_tid_q      <= tx_tid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_hdr_q     <= rsp_hdr_d;
            err_q         <= err_d;
            idle_q        <= idle_d;
        end
    end

    assign tx_valid        = tx_valid_q;
    assign tx_hdr          = tx_hdr_q;
    assign tx_tid          = tx_tid_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_hdr         = rsp_hdr_q;
    assign outstanding     = outstanding_q;
    assign idle            = idle_q;
    assign err_unknown_tid = err_q;

endmodule

// File: tb/tb_ccip_tx_tid_scheduler.sv
// Randomized bench for the TX tid scheduler, compared cycle by cycle against a
// behavioural model of the tid pool, fence slot and round-robin order.
module tb_ccip_tx_tid_scheduler;
    import ccip_tx_tid_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int MO = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NR-1:0] req_valid;
    TxHdr_t [NR-1:0] req_hdr;
    logic [NR-1:0] req_ready;
    logic          tx_almfull;
    logic          tx_valid;
    TxHdr_t        tx_hdr;
    logic [TW-1:0] tx_tid;
    logic          rx_valid;
    RxHdr_t        rx_hdr;
    logic [TW-1:0] rx_tid;
    logic [NR-1:0] rsp_valid;
    RxHdr_t        rsp_hdr;
    logic [TW:0]   outstanding;
    logic          idle;
    logic          err_unknown_tid;

    ccip_tx_tid_scheduler #(
        .NUM_REQ         (NR),
        .MAX_OUTSTANDING (MO),
        .TID_WIDTH       (TW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_hdr         (req_hdr),
        .req_ready       (req_ready),
        .tx_almfull      (tx_almfull),
        .tx_valid        (tx_valid),
        .tx_hdr          (tx_hdr),
        .tx_tid          (tx_tid),
        .rx_valid        (rx_valid),
        .rx_hdr          (rx_hdr),
        .rx_tid          (rx_tid),
        .rsp_valid       (rsp_valid),
        .rsp_hdr         (rsp_hdr),
        .outstanding     (outstanding),
        .idle            (idle),
        .err_unknown_tid (err_unknown_tid)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: which tids are live, whose they are, how many lines each still expects.
    int     m_owner [MO];
    int     m_rem   [MO];
    bit     m_valid [MO];
    int     m_ptr, m_out, m_fowner, m_gnt;
    bit     m_fpend;
    bit     e_txv, e_err, e_idle;
    TxHdr_t e_txh;
    int     e_tid;
    logic [NR-1:0] e_rsp;
    RxHdr_t e_rsph;
    bit     p_v   [NR];
    TxHdr_t p_hdr [NR];
    int     af_left;

    task automatic model_reset();
        for (int t = 0; t < MO; t++) begin
            m_valid[t] = 1'b0;
            m_owner[t] = 0;
            m_rem[t]   = 0;
        end
        m_ptr = 0; m_out = 0; m_fpend = 1'b0; m_fowner = 0; m_gnt = -1;
        e_txv = 1'b0; e_err = 1'b0; e_idle = 1'b1; e_txh = '0; e_tid = 0;
        e_rsp = '0; e_rsph = '0;
        for (int i = 0; i < NR; i++) p_v[i] = 1'b0;
        af_left = 0;
    endtask

    function automatic int first_free();
        for (int t = 0; t < MO; t++) if (!m_valid[t]) return t;
        return -1;
    endfunction

    function automatic TxHdr_t rand_hdr();
        TxHdr_t h;
        int r;
        r = int'($urandom_range(99));
        h.mdata = 16'($urandom);
        h.addr  = {10'($urandom), 32'($urandom)};
        h.len   = 2'($urandom);
        if (r < 6)       h.req_type = CCIP_WRFENCE;
        else if (r < 35) h.req_type = CCIP_RDLINE_I;
        else if (r < 55) h.req_type = CCIP_RDLINE_S;
        else if (r < 80) h.req_type = CCIP_WRLINE_I;
        else             h.req_type = CCIP_WRLINE_M;
        return h;
    endfunction

    // Evaluate one clock of the model on the inputs currently driven.
    task automatic model_step();
        logic [NR-1:0] rdy;
        int i, ft, t;
        bit fence_ret;
        rdy = '0; m_gnt = -1; fence_ret = 1'b0;
        for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (m_gnt < 0 && req_valid[i] && !tx_almfull) begin
                if (req_hdr[i].req_type == CCIP_WRFENCE) begin
                    if (!m_fpend) m_gnt = i;
                end else if (m_out < MO) begin
                    m_gnt = i;
                end
            end
        end
        if (m_gnt >= 0) rdy[m_gnt] = 1'b1;
        chk_eq("req_ready", 64'(req_ready), 64'(rdy));

        ft = first_free();
        e_rsp = '0; e_err = 1'b0;
        if (rx_valid) begin
            e_rsph = rx_hdr;
            t = int'(rx_tid);
            if (rx_hdr.resp_type == CCIP_RSP_WRFENCE) begin
                if (m_fpend) begin
                    e_rsp[m_fowner] = 1'b1;
                    fence_ret = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end else if (m_valid[t]) begin
                e_rsp[m_owner[t]] = 1'b1;
                m_rem[t]--;
                if (m_rem[t] == 0) begin
                    m_valid[t] = 1'b0;
                    m_out--;
                end
            end else begin
                e_err = 1'b1;
            end
        end
        if (fence_ret) m_fpend = 1'b0;

        e_txv = (m_gnt >= 0);
        if (e_txv) begin
            e_txh = req_hdr[m_gnt];
            if (e_txh.req_type == CCIP_WRFENCE) begin
                e_tid = 0;
                m_fpend = 1'b1;
                m_fowner = m_gnt;
            end else begin
                e_tid = ft;
                m_valid[ft] = 1'b1;
                m_owner[ft] = m_gnt;
                m_rem[ft] = (e_txh.req_type == CCIP_RDLINE_I || e_txh.req_type == CCIP_RDLINE_S)
                          ? int'(e_txh.len) + 1 : 1;
                m_out++;
            end
            m_ptr = (m_gnt + 1) % NR;
        end
        e_idle = (m_out == 0) && !e_txv && !m_fpend;
    endtask

    task automatic check_outputs();
        chk_eq("tx_valid", 64'(tx_valid), 64'(e_txv));
        if (e_txv) begin
            chk_eq("tx_hdr", 64'(tx_hdr), 64'(e_txh));
            chk_eq("tx_tid", 64'(tx_tid), 64'(e_tid));
        end
        chk_eq("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (e_rsp != '0) chk_eq("rsp_hdr", 64'(rsp_hdr), 64'(e_rsph));
        chk_eq("err_unknown_tid", 64'(err_unknown_tid), 64'(e_err));
        chk_eq("outstanding", 64'(outstanding), 64'(m_out));
        chk_eq("idle", 64'(idle), 64'(e_idle));
    endtask

    task automatic drive_random(input int p_req, input int p_rx, input int p_af, input int p_bad);
        int q[$];
        for (int i = 0; i < NR; i++) begin
            if (!p_v[i] && int'($urandom_range(99)) < p_req) begin
                p_v[i]   = 1'b1;
                p_hdr[i] = rand_hdr();
            end
            req_valid[i] = p_v[i];
            req_hdr[i]   = p_hdr[i];
        end
        if (af_left > 0) af_left--;
        else if (int'($urandom_range(99)) < p_af) af_left = int'($urandom_range(10, 1));
        tx_almfull = (af_left > 0);

        rx_valid = 1'b0; rx_hdr = '0; rx_tid = '0;
        if (int'($urandom_range(99)) < p_rx) begin
            rx_valid = 1'b1;
            rx_hdr.mdata = 16'($urandom);
            rx_hdr.clnum = 2'($urandom);
            rx_hdr.hit_miss = 1'($urandom);
            rx_hdr.resp_type = CCIP_RSP_RDLINE;
            for (int t = 0; t < MO; t++) if (m_valid[t]) q.push_back(t);
            if (m_fpend && $urandom_range(3) == 0) begin
                rx_hdr.resp_type = CCIP_RSP_WRFENCE;
            end else if (int'($urandom_range(99)) < p_bad) begin
                if (!m_fpend && $urandom_range(4) == 0) rx_hdr.resp_type = CCIP_RSP_WRFENCE;
                rx_tid = TW'($urandom);
            end else if (q.size() > 0) begin
                rx_tid = TW'(q[$urandom_range(q.size() - 1)]);
            end else begin
                rx_tid = TW'($urandom);
            end
        end
    endtask

    task automatic cycle(input int p_req, input int p_rx, input int p_af, input int p_bad);
        @(negedge clk);
        drive_random(p_req, p_rx, p_af, p_bad);
        #1;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        if (m_gnt >= 0) p_v[m_gnt] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0; req_hdr = '0; tx_almfull = 1'b0;
        rx_valid = 1'b0; rx_hdr = '0; rx_tid = '0;
        model_reset();
        #1;
        chk_eq("rst_outstanding", 64'(outstanding), 64'd0);
        chk_eq("rst_idle", 64'(idle), 64'd1);
        chk_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk_eq("rst_err", 64'(err_unknown_tid), 64'd0);
        chk_eq("rst_tx_hdr", 64'(tx_hdr), 64'd0);
        chk_eq("rst_tx_tid", 64'(tx_tid), 64'd0);
        chk_eq("rst_rsp_hdr", 64'(rsp_hdr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic late_rsp_cycle(input int tid);
        @(negedge clk);
        req_valid = '0; tx_almfull = 1'b0;
        rx_valid = 1'b1; rx_hdr = '0; rx_hdr.resp_type = CCIP_RSP_RDLINE;
        rx_hdr.mdata = 16'hbeef; rx_tid = TW'(tid);
        #1;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        req_valid = '0; req_hdr = '0; tx_almfull = 1'b0;
        rx_valid = 1'b0; rx_hdr = '0; rx_tid = '0;
        do_reset();
        repeat (300) cycle(50, 50, 5, 10);
        repeat (300) cycle(100, 8, 0, 5);
        repeat (200) cycle(70, 60, 25, 10);
        for (int n = 0; n < 200 && m_out < 3; n++) cycle(100, 0, 0, 0);
        do_reset();
        late_rsp_cycle(1);
        repeat (400) cycle(60, 55, 10, 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
